// File: rtl/mover_inject_ctrl.sv
// Photon loop injection scheduler: picks new vs recirculated photon for the mover mux,
// tracks launched/live photon counts and sequences run -> drain -> done.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | injecting new photons into dead slots until the total is launched
// DRAIN | all photons launched, waiting for the loop to empty
// DONE  | run complete, done held until the next start
module mover_inject_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int PIPE_DEPTH = 37
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] total_photons_i,
  input  logic                 dead_loop_i,
  input  logic                 kill_event_i,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  output logic                 sel_new_o,
  output logic [CNT_WIDTH-1:0] launched_count_o,
  output logic [CNT_WIDTH-1:0] live_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_underflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] launched_q, launched_d;
  logic [CNT_WIDTH-1:0] live_q, live_d;
  logic                 err_q, err_d;

  logic                 inject;
  logic                 kill_dec;
  logic                 err_set;
  logic [CNT_WIDTH-1:0] inject_w;
  logic [CNT_WIDTH-1:0] kill_w;
  logic [CNT_WIDTH-1:0] launched_inc;
  logic [CNT_WIDTH-1:0] live_next;

  // Reset gates inject so the mux select is clean while the loop is being flushed.
  assign inject = reset_i & enable_i & (state_q == S_RUN) & dead_loop_i &
                  launch_valid_i & (launched_q < total_q);

  assign kill_dec     = kill_event_i & (live_q != '0);
  assign err_set      = kill_event_i & (live_q == '0) & ~inject;
  assign inject_w     = {{(CNT_WIDTH-1){1'b0}}, inject};
  assign kill_w       = {{(CNT_WIDTH-1){1'b0}}, kill_dec};
  assign launched_inc = launched_q + inject_w;
  assign live_next    = live_q + inject_w - kill_w;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    launched_d = launched_q;
    live_d     = live_q;
    err_d      = err_q;

    if (enable_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            total_d    = total_photons_i;
            launched_d = '0;
            live_d     = '0;
            err_d      = 1'b0;
            state_d    = (total_photons_i == '0) ? S_DONE : S_RUN;
          end else begin
            live_d = live_next;
            if (err_set) err_d = 1'b1;
          end
        end
        S_RUN: begin
          launched_d = launched_inc;
          live_d     = live_next;
          if (err_set) err_d = 1'b1;
          if (launched_inc == total_q) begin
            state_d = (live_next == '0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          live_d = live_next;
          if (err_set) err_d = 1'b1;
          if (live_next == '0) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      launched_q <= '0;
      live_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      launched_q <= launched_d;
      live_q     <= live_d;
      err_q      <= err_d;
    end
  end

  // The loop has only PIPE_DEPTH slots, so more live photons means a broken kill/inject source.
  assert property (@(posedge clock_i) disable iff (!reset_i)
                   live_q <= CNT_WIDTH'(PIPE_DEPTH));

  assign sel_new_o        = inject;
  assign launch_ready_o   = inject;
  assign launched_count_o = launched_q;
  assign live_count_o     = live_q;
  assign busy_o           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o           = (state_q == S_DONE);
  assign err_underflow_o  = err_q;

endmodule

// File: tb/tb_mover_inject_ctrl.sv
// Scenario bench for mover_inject_ctrl: expected mux selects are queued as stimulus is
// driven and popped when the combinational select is sampled; counters checked inline.
module tb_mover_inject_ctrl;

  localparam int CW    = 32;
  localparam int DEPTH = 37;

  logic          clk;
  logic          rst_b;
  logic          enable;
  logic          start;
  logic [CW-1:0] total_photons;
  logic          dead_loop;
  logic          kill_event;
  logic          launch_valid;
  logic          launch_ready;
  logic          sel_new;
  logic [CW-1:0] launched_count;
  logic [CW-1:0] live_count;
  logic          busy;
  logic          done;
  logic          err_underflow;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];
  logic obs_sel, obs_rdy, e;

  mover_inject_ctrl #(.CNT_WIDTH(CW), .PIPE_DEPTH(DEPTH)) dut (
    .clock_i          (clk),
    .reset_i          (rst_b),
    .enable_i         (enable),
    .start_i          (start),
    .total_photons_i  (total_photons),
    .dead_loop_i      (dead_loop),
    .kill_event_i     (kill_event),
    .launch_valid_i   (launch_valid),
    .launch_ready_o   (launch_ready),
    .sel_new_o        (sel_new),
    .launched_count_o (launched_count),
    .live_count_o     (live_count),
    .busy_o           (busy),
    .done_o           (done),
    .err_underflow_o  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      n_cmp++;
      if (live_count > DEPTH) begin
        n_err++;
        $display("FAIL live_bound: live_count=%0d above depth %0d", live_count, DEPTH);
      end
    end
  end

  // One clock: drive at negedge, sample the combinational select mid-cycle,
  // return 1 time unit after the posedge so registered outputs are settled.
  task automatic step(input logic en, input logic st, input logic dl,
                      input logic kv, input logic lv);
    @(negedge clk);
    enable = en; start = st; dead_loop = dl; kill_event = kv; launch_valid = lv;
    #2;
    obs_sel = sel_new;
    obs_rdy = launch_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    total_photons = 5;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, obs_rdy} !== {e, e}) begin
        n_err++;
        $display("FAIL reset_sel c%0d: sel=%b rdy=%b want %b", i, obs_sel, obs_rdy, e);
      end
      n_cmp++;
      if ({launched_count, live_count, busy, done, err_underflow} !== {CW'(0), CW'(0), 3'b000}) begin
        n_err++;
        $display("FAIL reset_state c%0d: launched=%0d live=%0d busy=%b done=%b err=%b want all 0",
                 i, launched_count, live_count, busy, done, err_underflow);
      end
    end
    rst_b = 1'b1;
    exp_q.push_back(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_sel, obs_rdy} !== {e, e}) begin
      n_err++;
      $display("FAIL release_sel: sel=%b rdy=%b want %b", obs_sel, obs_rdy, e);
    end
    n_cmp++;
    if ({busy, done, launched_count} !== {2'b10, CW'(0)}) begin
      n_err++;
      $display("FAIL release_run: busy=%b done=%b launched=%0d want busy=1 done=0 launched=0",
               busy, done, launched_count);
    end
  endtask

  task automatic test_full_run();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i < 5);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, obs_rdy} !== {e, e}) begin
        n_err++;
        $display("FAIL full_sel c%0d: sel=%b rdy=%b want %b", i, obs_sel, obs_rdy, e);
      end
    end
    n_cmp++;
    if ({launched_count, live_count, busy, done} !== {CW'(5), CW'(5), 2'b10}) begin
      n_err++;
      $display("FAIL full_counts: launched=%0d live=%0d busy=%b done=%b want 5 5 1 0",
               launched_count, live_count, busy, done);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, live_count, done} !== {e, CW'(5 - k), k == 5}) begin
        n_err++;
        $display("FAIL full_drain k%0d: sel=%b live=%0d done=%b want sel=%b live=%0d done=%b",
                 k, obs_sel, live_count, done, e, 5 - k, k == 5);
      end
    end
  endtask

  task automatic test_alternating();
    total_photons = 3;
    exp_q.push_back(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_sel, busy, done, launched_count} !== {e, 2'b10, CW'(0)}) begin
      n_err++;
      $display("FAIL alt_start: sel=%b busy=%b done=%b launched=%0d want sel=0 busy=1 done=0 launched=0",
               obs_sel, busy, done, launched_count);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back((i % 2) == 0);
      step(1'b1, 1'b0, (i % 2) == 0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, obs_rdy, launched_count} !== {e, e, CW'(i / 2 + 1)}) begin
        n_err++;
        $display("FAIL alt_c%0d: sel=%b rdy=%b launched=%0d want sel=%b launched=%0d",
                 i, obs_sel, obs_rdy, launched_count, e, i / 2 + 1);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    n_cmp++;
    if ({live_count, done, busy} !== {CW'(0), 2'b10}) begin
      n_err++;
      $display("FAIL alt_done: live=%0d done=%b busy=%b want 0 1 0", live_count, done, busy);
    end
  endtask

  task automatic test_inject_kill();
    total_photons = 4;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_sel, launched_count, live_count} !== {e, CW'(3), CW'(2)}) begin
      n_err++;
      $display("FAIL ik_same_cycle: sel=%b launched=%0d live=%0d want sel=1 launched=3 live=2",
               obs_sel, launched_count, live_count);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({launched_count, live_count, busy} !== {CW'(4), CW'(3), 1'b1}) begin
      n_err++;
      $display("FAIL ik_last: launched=%0d live=%0d busy=%b want 4 3 1",
               launched_count, live_count, busy);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({live_count, done} !== {CW'(1), 1'b0}) begin
      n_err++;
      $display("FAIL ik_drain1: live=%0d done=%b want 1 0", live_count, done);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({live_count, done, busy} !== {CW'(0), 2'b10}) begin
      n_err++;
      $display("FAIL ik_done: live=%0d done=%b busy=%b want 0 1 0", live_count, done, busy);
    end
  endtask

  task automatic test_stall();
    total_photons = 6;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total_photons = 1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, obs_rdy, launched_count, live_count, busy} !== {e, e, CW'(2), CW'(2), 1'b1}) begin
        n_err++;
        $display("FAIL stall_c%0d: sel=%b rdy=%b launched=%0d live=%0d busy=%b want 0 0 2 2 1",
                 i, obs_sel, obs_rdy, launched_count, live_count, busy);
      end
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i < 4);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({obs_sel, obs_rdy} !== {e, e}) begin
        n_err++;
        $display("FAIL resume_c%0d: sel=%b rdy=%b want %b", i, obs_sel, obs_rdy, e);
      end
    end
    n_cmp++;
    if ({launched_count, live_count} !== {CW'(6), CW'(6)}) begin
      n_err++;
      $display("FAIL resume_counts: launched=%0d live=%0d want 6 6", launched_count, live_count);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done: done=%b want 1", done);
    end
  endtask

  task automatic test_zero_and_underflow();
    total_photons = 0;
    exp_q.push_back(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_sel, done, busy, launched_count} !== {e, 2'b10, CW'(0)}) begin
      n_err++;
      $display("FAIL zero_total: sel=%b done=%b busy=%b launched=%0d want 0 1 0 0",
               obs_sel, done, busy, launched_count);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({err_underflow, live_count, done} !== {1'b1, CW'(0), 1'b1}) begin
      n_err++;
      $display("FAIL underflow: err=%b live=%0d done=%b want 1 0 1", err_underflow, live_count, done);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (err_underflow !== 1'b1) begin
      n_err++;
      $display("FAIL underflow_sticky: err=%b want 1", err_underflow);
    end
    total_photons = 2;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({err_underflow, busy, done} !== 3'b010) begin
      n_err++;
      $display("FAIL underflow_clear: err=%b busy=%b done=%b want 0 1 0", err_underflow, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({done, launched_count} !== {1'b1, CW'(2)}) begin
      n_err++;
      $display("FAIL b2b_first: done=%b launched=%0d want 1 2", done, launched_count);
    end
    total_photons = 1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs_sel, launched_count, live_count, busy} !== {e, CW'(1), CW'(1), 1'b1}) begin
      n_err++;
      $display("FAIL b2b_second: sel=%b launched=%0d live=%0d busy=%b want 1 1 1 1",
               obs_sel, launched_count, live_count, busy);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({done, live_count} !== {1'b1, CW'(0)}) begin
      n_err++;
      $display("FAIL b2b_done: done=%b live=%0d want 1 0", done, live_count);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    dead_loop = 1'b0;
    kill_event = 1'b0;
    launch_valid = 1'b0;
    total_photons = '0;
    test_reset();
    test_full_run();
    test_alternating();
    test_inject_kill();
    test_stall();
    test_zero_and_underflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
